// File: rtl/door_pkg.sv
// Shared types and default geometry for the door plant model.
package door_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPENING = 2'd1,
    CLOSING = 2'd2,
    FAULT   = 2'd3
  } door_plant_state_t;

  localparam int DOOR_POS_MAX     = 16;
  localparam int DOOR_STEP_DIV    = 4;
  localparam int DOOR_OVERRUN_MAX = 8;

endpackage

// File: rtl/door_plant_model_step_prescaler.sv
// Modulo-MAX cycle counter with a one-cycle tick on wrap; the tick is
// suppressed on a cycle where the counter is being cleared.
module step_prescaler #(
  parameter int MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && !i_clr && (r_cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/door_plant_model.sv
// Plant side of the door controller: turns motor commands into a position
// counter with end-stop sensors, and latches a fault on illegal drive or overrun.
module door_plant_model
  import door_pkg::*;
#(
  parameter int POS_MAX     = DOOR_POS_MAX,
  parameter int STEP_DIV    = DOOR_STEP_DIV,
  parameter int OVERRUN_MAX = DOOR_OVERRUN_MAX
) (
  input  logic                         clk2m,
  input  logic                         rst,
  input  logic                         ml,
  input  logic                         mr,
  output logic                         sense_up,
  output logic                         sense_down,
  output logic [$clog2(POS_MAX+1)-1:0] pos,
  output logic                         moving,
  output logic                         fault
);

  localparam int PW = $clog2(POS_MAX + 1);
  localparam logic [PW-1:0] POS_TOP = PW'(POS_MAX);

  logic              r_ml;
  logic              r_mr;
  door_plant_state_t r_state;
  door_plant_state_t w_base_next;
  door_plant_state_t w_state_next;
  logic [PW-1:0]     r_pos;
  logic              w_moving;
  logic              w_at_stop;
  logic              w_div_clr;
  logic              w_div_tick;
  logic              w_ovr_clr;
  logic              w_ovr_tick;

  // Stage p0: motor commands are registered; all decisions use this sample.
  always_ff @(posedge clk2m) begin
    if (rst) begin
      r_ml <= 1'b0;
      r_mr <= 1'b0;
    end else begin
      r_ml <= ml;
      r_mr <= mr;
    end
  end

  assign w_moving  = (r_state == OPENING) || (r_state == CLOSING);
  assign w_at_stop = ((r_state == OPENING) && (r_pos == POS_TOP)) ||
                     ((r_state == CLOSING) && (r_pos == '0));

  // Command-driven next state; overrun is layered on top so the counter clears
  // can depend on this without a combinational loop through the overrun tick.
  always_comb begin
    w_base_next = IDLE;
    if ((r_state == FAULT) || (r_ml && r_mr)) begin
      w_base_next = FAULT;
    end else if (r_mr) begin
      w_base_next = OPENING;
    end else if (r_ml) begin
      w_base_next = CLOSING;
    end
  end

  always_comb begin
    w_state_next = w_base_next;
    if (w_ovr_tick) begin
      w_state_next = FAULT;
    end
  end

  assign w_div_clr = (w_base_next != r_state);
  assign w_ovr_clr = (w_base_next != r_state) || !w_at_stop;

  step_prescaler #(
    .MAX (STEP_DIV)
  ) u_div (
    .i_clk  (clk2m),
    .i_rst  (rst),
    .i_clr  (w_div_clr),
    .i_en   (w_moving),
    .o_tick (w_div_tick)
  );

  step_prescaler #(
    .MAX (OVERRUN_MAX)
  ) u_ovr (
    .i_clk  (clk2m),
    .i_rst  (rst),
    .i_clr  (w_ovr_clr),
    .i_en   (w_at_stop),
    .o_tick (w_ovr_tick)
  );

  // Stage p1: state and position registers.
  always_ff @(posedge clk2m) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk2m) begin
    if (rst) begin
      r_pos <= '0;
    end else if (w_div_tick) begin
      if ((r_state == OPENING) && (r_pos != POS_TOP)) begin
        r_pos <= r_pos + PW'(1);
      end else if ((r_state == CLOSING) && (r_pos != '0)) begin
        r_pos <= r_pos - PW'(1);
      end
    end
  end

  assign pos        = r_pos;
  assign sense_up   = (r_pos == POS_TOP);
  assign sense_down = (r_pos == '0);
  assign moving     = w_moving;
  assign fault      = (r_state == FAULT);

endmodule

// File: tb/tb_door_plant_model.sv
// Directed bench for door_plant_model with default geometry (16 steps, /4, overrun 8).
module tb_door_plant_model;

  logic       clk2m = 1'b0;
  logic       rst   = 1'b0;
  logic       ml    = 1'b0;
  logic       mr    = 1'b0;
  logic       sense_up;
  logic       sense_down;
  logic [4:0] pos;
  logic       moving;
  logic       fault;

  int checks = 0;
  int errors = 0;

  door_plant_model dut (
    .clk2m      (clk2m),
    .rst        (rst),
    .ml         (ml),
    .mr         (mr),
    .sense_up   (sense_up),
    .sense_down (sense_down),
    .pos        (pos),
    .moving     (moving),
    .fault      (fault)
  );

  always #5 clk2m = ~clk2m;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk2m);
    #1;
  endtask

  task automatic do_reset();
    ml  = 1'b0;
    mr  = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_pos(input logic [4:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (pos === target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pos !== 5'd0) begin errors++; $display("FAIL reset_pos: got %0d want 0", pos); end
    checks++; if (sense_down !== 1'b1) begin errors++; $display("FAIL reset_sense_down: got %b want 1", sense_down); end
    checks++; if (sense_up !== 1'b0) begin errors++; $display("FAIL reset_sense_up: got %b want 0", sense_up); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
    checks++; if (moving !== 1'b0) begin errors++; $display("FAIL reset_moving: got %b want 0", moving); end
  endtask

  task automatic test_full_open();
    do_reset();
    mr = 1'b1;
    repeat (5) tick();  // edge N+4
    checks++; if (pos !== 5'd0) begin errors++; $display("FAIL open_n4_pos: got %0d want 0", pos); end
    checks++; if (sense_down !== 1'b1) begin errors++; $display("FAIL open_n4_sdown: got %b want 1", sense_down); end
    tick();             // edge N+5
    checks++; if (pos !== 5'd1) begin errors++; $display("FAIL open_n5_pos: got %0d want 1", pos); end
    checks++; if (sense_down !== 1'b0) begin errors++; $display("FAIL open_n5_sdown: got %b want 0", sense_down); end
    checks++; if (moving !== 1'b1) begin errors++; $display("FAIL open_moving: got %b want 1", moving); end
    repeat (59) tick(); // edge N+64
    checks++; if (pos !== 5'd15) begin errors++; $display("FAIL open_n64_pos: got %0d want 15", pos); end
    checks++; if (sense_up !== 1'b0) begin errors++; $display("FAIL open_n64_sup: got %b want 0", sense_up); end
    tick();             // edge N+65
    checks++; if (pos !== 5'd16) begin errors++; $display("FAIL open_n65_pos: got %0d want 16", pos); end
    checks++; if (sense_up !== 1'b1) begin errors++; $display("FAIL open_n65_sup: got %b want 1", sense_up); end
    mr = 1'b0;
    repeat (3) tick();
    checks++; if (moving !== 1'b0) begin errors++; $display("FAIL open_idle_moving: got %b want 0", moving); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL open_idle_fault: got %b want 0", fault); end
    checks++; if (pos !== 5'd16) begin errors++; $display("FAIL open_idle_pos: got %0d want 16", pos); end
  endtask

  task automatic test_reversal();
    bit ok;
    do_reset();
    mr = 1'b1;
    wait_pos(5'd7, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rev_reach7: got pos %0d want 7", pos); end
    mr = 1'b0;
    ml = 1'b1;
    tick();
    tick();             // CLOSING entry edge E
    checks++; if (pos !== 5'd7) begin errors++; $display("FAIL rev_entry_pos: got %0d want 7", pos); end
    checks++; if (moving !== 1'b1) begin errors++; $display("FAIL rev_entry_moving: got %b want 1", moving); end
    repeat (4) tick();  // E+4
    checks++; if (pos !== 5'd6) begin errors++; $display("FAIL rev_e4_pos: got %0d want 6", pos); end
    repeat (23) tick(); // E+27
    checks++; if (pos !== 5'd1) begin errors++; $display("FAIL rev_e27_pos: got %0d want 1", pos); end
    checks++; if (sense_down !== 1'b0) begin errors++; $display("FAIL rev_e27_sdown: got %b want 0", sense_down); end
    tick();             // E+28
    checks++; if (pos !== 5'd0) begin errors++; $display("FAIL rev_e28_pos: got %0d want 0", pos); end
    checks++; if (sense_down !== 1'b1) begin errors++; $display("FAIL rev_e28_sdown: got %b want 1", sense_down); end
    ml = 1'b0;
    repeat (3) tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rev_fault: got %b want 0", fault); end
    checks++; if (moving !== 1'b0) begin errors++; $display("FAIL rev_idle_moving: got %b want 0", moving); end
  endtask

  task automatic test_overrun();
    bit ok;
    do_reset();
    mr = 1'b1;
    wait_pos(5'd16, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovr_reach16: got pos %0d want 16", pos); end
    repeat (7) tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL ovr_7_fault: got %b want 0", fault); end
    tick();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL ovr_8_fault: got %b want 1", fault); end
    checks++; if (pos !== 5'd16) begin errors++; $display("FAIL ovr_pos: got %0d want 16", pos); end
    checks++; if (moving !== 1'b0) begin errors++; $display("FAIL ovr_moving: got %b want 0", moving); end
    checks++; if (sense_up !== 1'b1) begin errors++; $display("FAIL ovr_sup: got %b want 1", sense_up); end
    mr = 1'b0;
    repeat (4) tick();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", fault); end
  endtask

  task automatic test_illegal_drive();
    bit ok;
    do_reset();
    mr = 1'b1;
    wait_pos(5'd5, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ill_reach5: got pos %0d want 5", pos); end
    ml = 1'b1;
    tick();
    ml = 1'b0;
    tick();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL ill_fault: got %b want 1", fault); end
    checks++; if (pos !== 5'd5) begin errors++; $display("FAIL ill_pos: got %0d want 5", pos); end
    checks++; if (moving !== 1'b0) begin errors++; $display("FAIL ill_moving: got %b want 0", moving); end
    repeat (20) tick();
    checks++; if (pos !== 5'd5) begin errors++; $display("FAIL ill_frozen_pos: got %0d want 5", pos); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL ill_sticky: got %b want 1", fault); end
    checks++; if (sense_down !== 1'b0) begin errors++; $display("FAIL ill_sdown: got %b want 0", sense_down); end
    do_reset();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL ill_rst_fault: got %b want 0", fault); end
    checks++; if (pos !== 5'd0) begin errors++; $display("FAIL ill_rst_pos: got %0d want 0", pos); end
  endtask

  task automatic test_reset_mid_motion();
    bit ok;
    do_reset();
    mr = 1'b1;
    wait_pos(5'd9, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmm_reach9: got pos %0d want 9", pos); end
    checks++; if (moving !== 1'b1) begin errors++; $display("FAIL rmm_moving_before: got %b want 1", moving); end
    rst = 1'b1;
    tick();
    checks++; if (pos !== 5'd0) begin errors++; $display("FAIL rmm_pos: got %0d want 0", pos); end
    checks++; if (sense_down !== 1'b1) begin errors++; $display("FAIL rmm_sdown: got %b want 1", sense_down); end
    checks++; if (moving !== 1'b0) begin errors++; $display("FAIL rmm_moving: got %b want 0", moving); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rmm_fault: got %b want 0", fault); end
    rst = 1'b0;
    mr  = 1'b0;
    repeat (3) tick();
    checks++; if (moving !== 1'b0) begin errors++; $display("FAIL rmm_idle: got %b want 0", moving); end
  endtask

  initial begin
    #1;
    test_reset();
    test_full_open();
    test_reversal();
    test_overrun();
    test_illegal_drive();
    test_reset_mid_motion();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
